gcm_tag_sequencer: RTL

Per-message controller for the GCM tag path. It accepts a message descriptor (AAD and text byte lengths, encrypted J0), admits AAD and ciphertext blocks from the CTR pipeline in order, and zero-pads partial last blocks. It issues those blocks into the GHASH chain, then issues the final length block with the final-stage ready strobe, and holds the resulting tag for the host until acknowledged. It sits between the CTR/AAD block sources and the GHASH pipeline's final tag stage.

---
 rtl/gcm_tag_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/gcm_tag_sequencer.sv
// ---------------------------------------------------------------------------
// gcm_tag_sequencer: per-message GCM tag-path block sequencer (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module gcm_tag_sequencer #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_aad_bytes,
  input  logic [LEN_W-1:0] i_text_bytes,
  input  logic [0:127]     i_encrypted_j0,
  output logic             o_busy,
  output logic             o_err,
  input  logic             i_blk_valid,
  input  logic [0:127]     i_blk_data,
  output logic             o_blk_ready,
  output logic             o_pipe_valid,
  output logic [0:127]     o_pipe_data,
  output logic             o_pipe_is_aad,
  output logic             o_pipe_final,
  output logic [0:127]     o_instance_size,
  output logic [0:127]     o_encrypted_j0,
  input  logic             i_tag_ready,
  input  logic [0:127]     i_tag,
  output logic             o_tag_valid,
  output logic [0:127]     o_tag,
  input  logic             i_tag_ack
);

  localparam int CNT_W = LEN_W - 3;

  typedef enum logic [2:0] {
    S_IDLE, S_AAD, S_TEXT, S_FINAL, S_WAIT_TAG, S_DONE
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_aad_bytes, r_text_bytes;
  logic [CNT_W-1:0] r_cnt;
  logic [0:127]     r_j0, r_tag, r_pipe_data;
  logic             r_pipe_valid, r_pipe_is_aad, r_pipe_final, r_err;

  logic             w_blk_ready, w_accept, w_last;
  logic [3:0]       w_rem;
  logic [0:127]     w_padded;
  logic [CNT_W-1:0] w_n_aad_in, w_n_text_in, w_n_text_lat;

  function automatic logic [CNT_W-1:0] f_blocks(input logic [LEN_W-1:0] len);
    return {1'b0, len[LEN_W-1:4]} + CNT_W'(|len[3:0]);
  endfunction

  assign w_n_aad_in   = f_blocks(i_aad_bytes);
  assign w_n_text_in  = f_blocks(i_text_bytes);
  assign w_n_text_lat = f_blocks(r_text_bytes);

  assign w_blk_ready = (r_state == S_AAD) || (r_state == S_TEXT);
  assign w_accept    = i_blk_valid && w_blk_ready;
  assign w_last      = (r_cnt == CNT_W'(1));
  assign w_rem       = (r_state == S_AAD) ? r_aad_bytes[3:0] : r_text_bytes[3:0];

  // Only the last block of a section with a partial tail is masked.
  always_comb begin
    w_padded = i_blk_data;
    if (w_last && (w_rem != 4'd0)) begin
      for (int k = 0; k < 16; k++) begin
        if (k >= int'(w_rem)) w_padded[8*k +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_aad_bytes   <= '0;
      r_text_bytes  <= '0;
      r_cnt         <= '0;
      r_j0          <= '0;
      r_tag         <= '0;
      r_pipe_data   <= '0;
      r_pipe_valid  <= 1'b0;
      r_pipe_is_aad <= 1'b0;
      r_pipe_final  <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_pipe_valid  <= 1'b0;
      r_pipe_is_aad <= 1'b0;
      r_pipe_final  <= 1'b0;
      r_err         <= i_start && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_aad_bytes  <= i_aad_bytes;
            r_text_bytes <= i_text_bytes;
            r_j0         <= i_encrypted_j0;
            if (w_n_aad_in != '0) begin
              r_state <= S_AAD;
              r_cnt   <= w_n_aad_in;
            end else if (w_n_text_in != '0) begin
              r_state <= S_TEXT;
              r_cnt   <= w_n_text_in;
            end else begin
              r_state      <= S_FINAL;
              r_pipe_valid <= 1'b1;
              r_pipe_final <= 1'b1;
              r_pipe_data  <= '0;
            end
          end
        end
        S_AAD, S_TEXT: begin
          if (w_accept) begin
            r_pipe_valid  <= 1'b1;
            r_pipe_data   <= w_padded;
            r_pipe_is_aad <= (r_state == S_AAD);
            r_cnt         <= r_cnt - CNT_W'(1);
            if (w_last) begin
              // The last data block and the final strobe leave together.
              if ((r_state == S_AAD) && (w_n_text_lat != '0)) begin
                r_state <= S_TEXT;
                r_cnt   <= w_n_text_lat;
              end else begin
                r_state      <= S_FINAL;
                r_pipe_final <= 1'b1;
              end
            end
          end
        end
        S_FINAL: r_state <= S_WAIT_TAG;
        S_WAIT_TAG: begin
          if (i_tag_ready) begin
            r_tag   <= i_tag;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_tag_ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy          = (r_state != S_IDLE);
  assign o_err           = r_err;
  assign o_blk_ready     = w_blk_ready;
  assign o_pipe_valid    = r_pipe_valid;
  assign o_pipe_data     = r_pipe_data;
  assign o_pipe_is_aad   = r_pipe_is_aad;
  assign o_pipe_final    = r_pipe_final;
  assign o_instance_size = {64'(r_aad_bytes) << 3, 64'(r_text_bytes) << 3};
  assign o_encrypted_j0  = r_j0;
  assign o_tag_valid     = (r_state == S_DONE);
  assign o_tag           = r_tag;

endmodule

`default_nettype wire
